// File: rtl/beep_pkg.sv
// Shared definitions for the melody sequencer: note codes, pitch table, FSM states.
package beep_pkg;

  localparam logic [3:0] REST = 4'd0;
  localparam logic [3:0] C4   = 4'd1;
  localparam logic [3:0] D4   = 4'd2;
  localparam logic [3:0] E4   = 4'd3;
  localparam logic [3:0] F4   = 4'd4;
  localparam logic [3:0] G4   = 4'd5;
  localparam logic [3:0] A4   = 4'd6;
  localparam logic [3:0] B4   = 4'd7;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_NOTE, S_GAP, S_DONE} state_t;

  typedef struct packed {
    logic [3:0] code;
    logic [2:0] dur;
  } note_t;

  function automatic logic is_tone(input logic [3:0] code);
    return (code >= C4) && (code <= B4);
  endfunction

  // Half-period counts at 50 MHz: round(25e6 / f).
  function automatic logic [31:0] note_period(input logic [3:0] code);
    case (code)
      C4:      return 32'd95420;
      D4:      return 32'd85034;
      E4:      return 32'd75758;
      F4:      return 32'd71633;
      G4:      return 32'd63776;
      A4:      return 32'd56818;
      B4:      return 32'd50607;
      default: return 32'd0;
    endcase
  endfunction

endpackage

// File: rtl/melody_rom.sv
// Fixed song ROM: 4-bit address to {code, dur}.
module melody_rom
  import beep_pkg::*;
(
  input  logic [3:0] addr,
  output note_t      entry
);

  always_comb begin
    entry = '{code: REST, dur: 3'd0};
    case (addr)
      4'd0: entry = '{code: C4, dur: 3'd1};
      4'd1: entry = '{code: D4, dur: 3'd1};
      4'd2: entry = '{code: E4, dur: 3'd1};
      4'd3: entry = '{code: C4, dur: 3'd1};
      4'd4: entry = '{code: G4, dur: 3'd3};
      4'd5: entry = '{code: REST, dur: 3'd0};
      4'd6: entry = '{code: G4, dur: 3'd3};
      4'd7: entry = '{code: B4, dur: 3'd0};
      default: ;
    endcase
  end

endmodule

// File: rtl/melody_seq.sv
// Melody sequencer: walks the note ROM and drives the beep counter's period/enable.
module melody_seq
  import beep_pkg::*;
#(
  parameter int DUR_UNIT = 12_500_000,
  parameter int GAP_CYC  = 2_500_000,
  parameter int NOTE_NUM = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        play,
  input  logic        loop_en,
  output logic [31:0] cnt_acc,
  output logic        mode,
  output logic        cnt_going,
  output logic [3:0]  note_idx,
  output logic        busy,
  output logic        done
);

  localparam int DW = $clog2(8 * DUR_UNIT);
  localparam int GW = (GAP_CYC < 2) ? 1 : $clog2(GAP_CYC + 1);

  state_t         state, state_nx;
  logic [DW-1:0]  dur_cnt;
  logic [GW-1:0]  gap_cnt;
  logic           armed;
  logic           last;
  note_t          entry;

  melody_rom u_rom (
    .addr  (note_idx),
    .entry (entry)
  );

  assign last      = (note_idx == 4'(NOTE_NUM - 1));
  assign cnt_going = (state == S_NOTE) && is_tone(entry.code);
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (play && armed) state_nx = S_LOAD;
      S_LOAD: state_nx = S_NOTE;
      S_NOTE: if (dur_cnt == '0) state_nx = S_GAP;
      S_GAP:  if (gap_cnt == '0) state_nx = (!last || loop_en) ? S_LOAD : S_DONE;
      S_DONE: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    if (!play && state != S_IDLE) state_nx = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt_acc  <= '0;
      note_idx <= '0;
      dur_cnt  <= '0;
      gap_cnt  <= '0;
      mode     <= 1'b0;
      armed    <= 1'b1;
    end else begin
      state <= state_nx;
      mode  <= 1'b1;
      // A finished pass must see play low before it may start again.
      if (!play)                armed <= 1'b1;
      else if (state == S_DONE) armed <= 1'b0;

      if (state_nx == S_IDLE) begin
        cnt_acc  <= '0;
        note_idx <= '0;
        dur_cnt  <= '0;
        gap_cnt  <= '0;
      end else begin
        case (state)
          S_LOAD: begin
            cnt_acc <= note_period(entry.code);
            dur_cnt <= DW'((int'(entry.dur) + 1) * DUR_UNIT - 1);
          end
          S_NOTE: begin
            if (dur_cnt == '0) gap_cnt <= GW'(GAP_CYC - 1);
            else               dur_cnt <= dur_cnt - 1'b1;
          end
          S_GAP: begin
            if (gap_cnt != '0)           gap_cnt  <= gap_cnt - 1'b1;
            else if (state_nx == S_LOAD) note_idx <= last ? 4'd0 : note_idx + 4'd1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_melody_seq.sv
// Directed bench for melody_seq with short durations (DUR_UNIT=100, GAP_CYC=10, NOTE_NUM=8).
module tb_melody_seq;

  localparam int DUR = 100;
  localparam int GAP = 10;
  localparam int NN  = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        play = 1'b1;
  logic        loop_en = 1'b0;
  logic [31:0] cnt_acc;
  logic        mode, cnt_going, busy, done;
  logic [3:0]  note_idx;

  int n_chk = 0;
  int n_fail = 0;
  int done_cnt = 0;
  logic        prev_go = 1'b0;
  logic [31:0] prev_acc = '0;

  int exp_acc [NN] = '{95420, 85034, 75758, 95420, 63776, 0, 63776, 50607};
  int exp_dur [NN] = '{1, 1, 1, 1, 3, 0, 3, 0};

  melody_seq #(.DUR_UNIT(DUR), .GAP_CYC(GAP), .NOTE_NUM(NN)) dut (
    .clk(clk), .rst(rst), .play(play), .loop_en(loop_en),
    .cnt_acc(cnt_acc), .mode(mode), .cnt_going(cnt_going),
    .note_idx(note_idx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Pitch must never change while the counter is enabled.
  always @(negedge clk) begin
    if (prev_go && cnt_going) chk("acc_stable", cnt_acc, prev_acc);
    if (done === 1'b1) done_cnt++;
    prev_go  = (cnt_going === 1'b1);
    prev_acc = cnt_acc;
  end

  // Entered at the first NOTE cycle of note i; leaves at the next NOTE entry or in IDLE after DONE.
  task automatic run_note(input int i, input bit lp);
    int len;
    logic tone;
    len  = (exp_dur[i] + 1) * DUR;
    tone = (exp_acc[i] != 0);
    chk("note_idx", note_idx, i);
    chk("note_acc", cnt_acc, exp_acc[i]);
    chk("note_going_first", cnt_going, tone);
    chk("note_busy", busy, 1);
    cyc(len - 1);
    chk("note_going_last", cnt_going, tone);
    cyc(1);
    chk("gap_going", cnt_going, 0);
    chk("gap_acc_hold", cnt_acc, exp_acc[i]);
    if (i < NN - 1 || lp) begin
      cyc(GAP);
      chk("load_going", cnt_going, 0);
      chk("load_busy", busy, 1);
      chk("load_done", done, 0);
      cyc(1);
    end else begin
      cyc(GAP - 1);
      chk("gap_end_done", done, 0);
      cyc(1);
      chk("done_pulse", done, 1);
      chk("done_busy", busy, 1);
      cyc(1);
      chk("idle_done", done, 0);
      chk("idle_busy", busy, 0);
      chk("idle_acc", cnt_acc, 0);
      chk("idle_idx", note_idx, 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with play high: everything reads zero, including mode.
    for (int k = 0; k < 5; k++) begin
      cyc(1);
      chk("rst_acc", cnt_acc, 0);
      chk("rst_flags", {mode, cnt_going, note_idx, busy, done}, 0);
    end
    rst  = 1'b0;
    play = 1'b0;
    cyc(1);
    chk("post_rst_mode", mode, 1);
    chk("post_rst_busy", busy, 0);
    cyc(3);
    chk("idle_busy_hold", busy, 0);

    // Single pass, no loop.
    play = 1'b1;
    cyc(1);
    chk("first_load_busy", busy, 1);
    chk("first_load_going", cnt_going, 0);
    chk("first_load_acc", cnt_acc, 0);
    cyc(1);
    for (int i = 0; i < NN; i++) run_note(i, 1'b0);
    cyc(5);
    chk("no_autorestart", busy, 0);
    chk("one_done", done_cnt, 1);

    // Looping pass: wraps 7 -> 0 with no done pulse.
    play = 1'b0;
    cyc(1);
    loop_en = 1'b1;
    play    = 1'b1;
    cyc(1);
    chk("loop_load_busy", busy, 1);
    cyc(1);
    for (int i = 0; i < NN; i++) run_note(i, 1'b1);
    chk("wrap_done_cnt", done_cnt, 1);

    // Stop mid-note at idx 2, then restart from the top.
    run_note(0, 1'b1);
    run_note(1, 1'b1);
    chk("stop_idx2", note_idx, 2);
    cyc(50);
    play = 1'b0;
    cyc(1);
    chk("stop_going", cnt_going, 0);
    chk("stop_acc", cnt_acc, 0);
    chk("stop_idx", note_idx, 0);
    chk("stop_busy", busy, 0);
    play = 1'b1;
    cyc(2);
    run_note(0, 1'b1);

    // Reset pulse in the gap of idx 1.
    cyc(200 + 3);
    chk("pre_rst_gap", {busy, cnt_going}, 2'b10);
    rst = 1'b1;
    cyc(1);
    chk("midrst_acc", cnt_acc, 0);
    chk("midrst_flags", {mode, cnt_going, note_idx, busy, done}, 0);
    rst  = 1'b0;
    play = 1'b0;
    cyc(1);
    chk("midrst_mode", mode, 1);
    chk("midrst_busy", busy, 0);
    cyc(3);
    chk("midrst_idle", {busy, cnt_going, done}, 0);
    chk("final_done_cnt", done_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
